alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_pkg.sv | 13 +
 rtl/alu_op_decode.sv | 14 +
 rtl/alu_op_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: opcodes, FSM states and instruction field positions
package alu_op_sequencer_pkg;
  localparam logic [2:0] OP_SUM = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int SRC_BIT = 4;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode to active-low one-hot strobe vector plus illegal flag
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [2:0] op,
  output logic [5:0] strobe_n,
  output logic       illegal
);
  // bit k of strobe_n drives the strobe for opcode k
  always_comb begin
    illegal = op > OP_SHR;
    strobe_n = illegal ? 6'h3f : ~(6'b1 << op);
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: three-state ALU op sequencer; ALU_SEQ_FLAGS_EN adds Zf/Dzf flags
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       Instr_valid,
  input  logic [7:0] Instr,
  input  logic [7:0] Operand,
  output logic       Instr_ready,
  output logic       ISUMn,
  output logic       ISUBn,
  output logic       IMULn,
  output logic       IDIVn,
  output logic       ISHLn,
  output logic       ISHRn,
  output logic       An,
  output logic       Bn,
  output logic [7:0] Din,
  input  logic [7:0] Alu_Dout,
  output logic [7:0] Result,
  output logic       Done,
  output logic       Err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic       Zf,
  output logic       Dzf
`endif
);
  state_t state;
  logic [5:0] strobe_n;
  logic [5:0] dec_strobe_n;
  logic dec_illegal;
  logic illegal_q;
  logic accept;
  logic unused_rsvd;
  alu_op_decode u_decode (
    .op(Instr[OP_MSB:OP_LSB]),
    .strobe_n(dec_strobe_n),
    .illegal(dec_illegal)
  );
  assign unused_rsvd = ^Instr[SRC_BIT-1:0];
  assign {ISHRn, ISHLn, IDIVn, IMULn, ISUBn, ISUMn} = strobe_n;
  assign Instr_ready = state == IDLE && !rst;
  assign accept = Instr_valid && Instr_ready;
  // sequencing: strobes and source selects are loaded on accept so they are registered for EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      strobe_n <= '1;
      An <= 1'b1;
      Bn <= 1'b1;
      Din <= '0;
      Result <= '0;
      Done <= 1'b0;
      Err <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state == IDLE ? (accept ? EXEC : IDLE) : state == EXEC ? WB : IDLE;
      Done <= state == EXEC;
      Err <= state == EXEC && illegal_q;
      strobe_n <= accept ? dec_strobe_n : '1;
      An <= accept ? Instr[SRC_BIT] : 1'b1;
      Bn <= accept ? !Instr[SRC_BIT] : 1'b1;
      if (accept) begin
        Din <= Operand;
        illegal_q <= dec_illegal;
      end
      if (state == EXEC && !illegal_q) Result <= Alu_Dout;
    end
  end
`ifdef ALU_SEQ_FLAGS_EN
  logic div_q;
  // flags follow the same write-back as Result and hold across illegal opcodes
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 1'b0;
      Zf <= 1'b0;
      Dzf <= 1'b0;
    end else begin
      if (accept) div_q <= Instr[OP_MSB:OP_LSB] == OP_DIV;
      if (state == EXEC && !illegal_q) begin
        Zf <= Alu_Dout == 8'h00;
        Dzf <= div_q && Din == 8'h00;
      end
    end
  end
`endif
endmodule
